fma16: RTL and testbench
========================

# fma16

Combinational IEEE 754 binary16 fused multiply-add unit computing ±(x·y) ± z with a single rounding, plus a configurable output register. It is the arithmetic core of the half-precision FPU datapath. Control bits select multiply-only, add-only or full FMA, operand negation and rounding mode. It returns the rounded result and IEEE exception flags.

## Interface
- Parameters: none.
- clk  input  1  clock; used only when the output register is compiled in.
- reset  input  1  asynchronous, active-low reset.
- x, y, z  input  16 each  binary16 operands.
- mul  input  1  1: use y as multiplier; 0: multiplier is 1.0.
- add  input  1  1: use z as addend; 0: no addend.
- negp  input  1  negate the product.
- negz  input  1  negate the addend.
- roundmode  input  2  rounding mode: 00 RZ, 01 RNE, 10 RM (toward −∞), 11 RP (toward +∞).
- result  output  16  rounded binary16 result.
- flags  output  4  {invalid, overflow, underflow, inexact}.

## Operation
- Product P = (−1)^negp · x · (mul ? y : 1.0), computed exactly: 22-bit significand product.
- Addend A depends on add:
  - add = 1: A = (−1)^negz · z.
  - add = 0: A = −0 and negz is ignored, so the result is the product alone with its zero sign preserved.
- Result = round(P + A) with a single rounding to 11-bit precision.
  - Internal alignment width is sufficient for an exact sum (≥ 3·11 + guard bits).
  - Sticky OR is taken of every shifted-out bit.
- Full subnormal support on inputs and outputs; no flush-to-zero.
- Exact zero sum of opposite-signed operands: +0, except −0 under RM. Same-signed zeros keep that sign.
- NaN handling:
  - Any NaN input yields canonical quiet NaN 7E00.
  - invalid is set for a signaling NaN input, ∞·0, or ∞ − ∞ after negation.
- Infinity arithmetic follows IEEE rules, with the sign derived after negp/negz.
- Overflow (rounded exponent > 30) sets overflow and inexact. The result depends on mode:
  - RNE: ±∞.
  - RZ: ±7BFF.
  - RM: −∞ for negative results, +7BFF for positive.
  - RP: +∞ for positive results, −7BFF for negative.
- Underflow: set when the result is tiny after rounding (nonzero magnitude < 2^−14) and inexact.
- Inexact: set whenever the rounded result ≠ the exact value.
- Unused operand fields still feed NaN/invalid detection only when selected:
  - y is ignored when mul = 0.
  - z is ignored when add = 0.

## Timing
- Default build: purely combinational. result and flags are valid within the same cycle as the inputs. clk and reset are unused.
- With FMA16_OUTREG_EN:
  - result and flags are registered on rising clk, giving latency 1 cycle and throughput 1 per cycle.
  - reset low asynchronously forces result = 0000 and flags = 0000, and holds them while low.
  - First capture occurs on the first rising edge after reset deasserts.
  - Reset asserted mid-operation discards the in-flight result.

## Configuration
- FMA16_OUTREG_EN defined: output register stage as described above.
- FMA16_OUTREG_EN undefined: outputs are driven directly by combinational logic.
- Arithmetic is identical in both builds.

## Test plan
- Multiply only: x=3E00, y=4000, mul=1, add=0, RNE → 4200, flags 0000.
- FMA: x=3C00, y=3C00, z=3C00, mul=add=1 → 4000. Same operands with negz=1:
  - RNE → 0000.
  - RM → 8000.
- Rounding: x=y=3C01, mul=1, add=0:
  - RNE → 3C02, flags 0001.
  - RP → 3C03.
  - RZ → 3C02.
- Overflow: x=7BFF, y=4000, mul=1:
  - RNE → 7C00, flags 0101.
  - RZ → 7BFF, flags 0101.
- Invalid: x=7C00, y=0000, mul=1 → 7E00, flags 1000. x=7C00, z=FC00, add=1, mul=0 → 7E00, flags 1000.
- Register build: assert reset low → outputs 0000/0000. Then apply x=3C00, y=3C00, mul=1 → result 3C00 appears after the next rising edge.

Source files
------------

// File: rtl/fma16.sv
// fma16: IEEE 754 binary16 fused multiply-add, result = round(+/-(x*y) +/- z)
// with a single rounding step and {invalid, overflow, underflow, inexact} flags.
// Build option: define FMA16_OUTREG_EN to add a one-cycle output register;
// without it, result and flags are purely combinational and clk/reset are unused.

module fma16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  // Fixed-point accumulator width. LSB weight is 2^-48 (the smallest product
  // LSB); the largest product reaches bit 79, so the sum fits in 81 bits with
  // no bit ever lost before rounding.
  localparam int W = 81;

  typedef enum logic [1:0] {
    RND_RZ  = 2'b00,
    RND_RNE = 2'b01,
    RND_RM  = 2'b10,
    RND_RP  = 2'b11
  } round_e;

  typedef struct packed {
    logic        sign;
    logic        nan;
    logic        snan;
    logic        inf;
    logic [4:0]  exp;  // effective biased exponent (subnormals use 1)
    logic [10:0] sig;  // significand including the hidden bit
  } operand_t;

  function automatic operand_t unpack16(input logic [15:0] v);
    operand_t o;
    o.sign = v[15];
    o.nan  = (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
    o.snan = o.nan && !v[9];
    o.inf  = (v[14:10] == 5'h1F) && (v[9:0] == 10'h000);
    o.exp  = (v[14:10] == 5'h00) ? 5'd1 : v[14:10];
    o.sig  = {v[14:10] != 5'h00, v[9:0]};
    return o;
  endfunction

  logic [15:0] b_op;
  logic [15:0] c_op;
  operand_t    a;
  operand_t    b;
  operand_t    c;
  logic        sp;
  logic        sc;

  // Operand selection: multiplier falls back to 1.0, addend to -0
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later lines see the
    // values computed above them within the same evaluation.
    b_op = mul ? y : 16'h3C00;
    c_op = add ? z : 16'h8000;
    a    = unpack16(x);
    b    = unpack16(b_op);
    c    = unpack16(c_op);
    sp   = a.sign ^ b.sign ^ negp;
    sc   = add ? (c.sign ^ negz) : 1'b1;
  end

  logic [21:0]  prod_sig;
  logic [6:0]   prod_shift;
  logic [6:0]   add_shift;
  logic [W-1:0] prod_fix;
  logic [W-1:0] add_fix;
  logic [W-1:0] sum;
  logic         sum_sign;

  // Exact alignment of product and addend, then signed-magnitude addition
  always_comb begin
    prod_sig   = 22'(a.sig) * 22'(b.sig);
    prod_shift = 7'(a.exp) + 7'(b.exp) - 7'd2;
    add_shift  = 7'(c.exp) + 7'd23;
    prod_fix   = W'(prod_sig) << prod_shift;
    add_fix    = W'(c.sig) << add_shift;
    if (sp == sc) begin
      sum      = prod_fix + add_fix;
      sum_sign = sp;
    end else if (prod_fix >= add_fix) begin
      sum      = prod_fix - add_fix;
      sum_sign = sp;
    end else begin
      sum      = add_fix - prod_fix;
      sum_sign = sc;
    end
  end

  logic [6:0]  lead;
  logic [6:0]  q;
  logic [10:0] kept;
  logic        guard;
  logic        sticky;
  logic        inexact;
  logic        inc;
  logic [11:0] kept_r;
  logic [16:0] mag;

  // Normalize and round: q is the bit position of the result ULP
  always_comb begin
    lead = 7'd0;
    for (int i = 0; i < W; i++) begin
      if (sum[i]) lead = 7'(i);
    end
    // Normal results keep 11 bits below the leading one; subnormals stop at 2^-24.
    q       = (lead >= 7'd34) ? (lead - 7'd10) : 7'd24;
    kept    = 11'(sum >> q);
    guard   = sum[q - 7'd1];
    sticky  = |(sum & ((W'(1) << (q - 7'd1)) - W'(1)));
    inexact = guard | sticky;
    inc     = 1'b0;
    case (roundmode)
      RND_RZ:  inc = 1'b0;
      RND_RNE: inc = guard & (sticky | kept[0]);
      RND_RM:  inc = sum_sign & inexact;
      RND_RP:  inc = !sum_sign & inexact;
      default: inc = 1'b0;
    endcase
    kept_r = {1'b0, kept} + {11'h000, inc};
    // The hidden bit carries into the exponent field, so a significand
    // rounding up to 2^11 (or a subnormal reaching 2^10) renormalizes itself.
    mag    = {q - 7'd24, 10'h000} + {5'h00, kept_r};
  end

  logic [15:0] res_c;
  logic [3:0]  flg_c;
  logic        any_nan;
  logic        any_snan;
  logic        inf_zero;
  logic        p_inf;

  // Special-case priority and final packing of result and flags
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the if/else chain can leave a value unassigned and infer a latch.
    res_c    = 16'h0000;
    flg_c    = 4'h0;
    any_nan  = a.nan | b.nan | c.nan;
    any_snan = a.snan | b.snan | c.snan;
    inf_zero = (a.inf && (b.sig == 11'h000)) || (b.inf && (a.sig == 11'h000));
    p_inf    = a.inf | b.inf;
    if (any_nan || inf_zero) begin
      res_c = 16'h7E00;
      flg_c = {any_snan | inf_zero, 3'b000};
    end else if (p_inf && c.inf && (sp != sc)) begin
      res_c = 16'h7E00;
      flg_c = 4'b1000;
    end else if (p_inf) begin
      res_c = {sp, 15'h7C00};
    end else if (c.inf) begin
      res_c = {sc, 15'h7C00};
    end else if (sum == '0) begin
      // Without an addend the product's zero sign passes through untouched.
      if (!add || (sp == sc)) res_c = {sp, 15'h0000};
      else                    res_c = {roundmode == RND_RM, 15'h0000};
    end else if (mag >= 17'h07C00) begin
      flg_c = 4'b0101;
      if ((roundmode == RND_RNE) ||
          ((roundmode == RND_RM) && sum_sign) ||
          ((roundmode == RND_RP) && !sum_sign))
        res_c = {sum_sign, 15'h7C00};
      else
        res_c = {sum_sign, 15'h7BFF};
    end else begin
      res_c = {sum_sign, mag[14:0]};
      // Tiny is judged on the rounded magnitude, including a round to zero.
      flg_c = {2'b00, inexact && (mag < 17'h00400), inexact};
    end
  end

`ifdef FMA16_OUTREG_EN
  // Output register: one cycle latency; reset discards whatever is in flight
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: registered state uses non-blocking '<=' so every flop samples
    // its input from before the edge, independent of statement order.
    if (!reset) begin
      result <= 16'h0000;
      flags  <= 4'h0;
    end else begin
      result <= res_c;
      flags  <= flg_c;
    end
  end
`else
  assign result = res_c;
  assign flags  = flg_c;

  // clk and reset only matter when the output register is built in.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;
`endif

endmodule

// File: tb/tb_fma16.sv
// tb_fma16: scoreboard bench for fma16. Expected responses come either from
// constants or from an exact-value reference model (integer value scaled by
// 2^48, rounded by searching the ordered binary16 codes). Works with or
// without FMA16_OUTREG_EN.

module tb_fma16;

  localparam logic [1:0] RZ  = 2'b00;
  localparam logic [1:0] RNE = 2'b01;
  localparam logic [1:0] RM  = 2'b10;
  localparam logic [1:0] RP  = 2'b11;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flg;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x, y, z;
  logic        mul, add, negp, negz;
  logic [1:0]  roundmode;
  logic [15:0] result;
  logic [3:0]  flags;

  int checks   = 0;
  int failures = 0;

  resp_t exp_q[$];
  string name_q[$];
  logic  in_valid = 1'b0;
  logic  out_valid;

  logic [15:0] specials [12] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                                 16'h7E00, 16'h7D00, 16'h0001, 16'h03FF,
                                 16'h0400, 16'h7BFF, 16'h3C00, 16'hFBFF};

  always #5 clk = ~clk;

  fma16 dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .z(z),
    .mul(mul), .add(add), .negp(negp), .negz(negz),
    .roundmode(roundmode), .result(result), .flags(flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: {result,flags} got %0h want %0h", name, act, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'h0);
  endfunction

  function automatic logic is_inf(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] == 10'h0);
  endfunction

  // |value| * 2^24 as an integer, for finite codes and 7C00 (= 2^16).
  function automatic logic [63:0] s24(input logic [15:0] v);
    logic [4:0] e;
    logic [9:0] f;
    e = v[14:10];
    f = v[9:0];
    if (e == 5'd0) return {54'h0, f};
    return {53'h0, 1'b1, f} << (e - 5'd1);
  endfunction

  function automatic logic [127:0] val48(input int code);
    logic [15:0] c16;
    c16 = 16'(code);
    return {64'h0, s24(c16)} << 24;
  endfunction

  function automatic resp_t ref_fma(input logic [15:0] xa, input logic [15:0] ya,
                                    input logic [15:0] za, input logic m, input logic ad,
                                    input logic np, input logic nz, input logic [1:0] rm);
    logic [15:0] bv, cv;
    logic sp_, sc_, nan_any, snan_any, iz, neg, exact, up, big;
    logic signed [129:0] pv, cvv, v;
    logic [127:0] mag, lo_v, hi_v;
    int lo, hi, mid, code;
    resp_t r;
    bv = m ? ya : 16'h3C00;
    cv = ad ? za : 16'h8000;
    sp_ = xa[15] ^ bv[15] ^ np;
    sc_ = ad ? (cv[15] ^ nz) : 1'b1;
    nan_any  = is_nan(xa) || is_nan(bv) || is_nan(cv);
    snan_any = (is_nan(xa) && !xa[9]) || (is_nan(bv) && !bv[9]) || (is_nan(cv) && !cv[9]);
    iz = (is_inf(xa) && bv[14:0] == 15'h0) || (is_inf(bv) && xa[14:0] == 15'h0);
    if (nan_any || iz) begin
      r.res = 16'h7E00; r.flg = {snan_any || iz, 3'b000}; return r;
    end
    if ((is_inf(xa) || is_inf(bv)) && is_inf(cv) && sp_ != sc_) begin
      r.res = 16'h7E00; r.flg = 4'b1000; return r;
    end
    if (is_inf(xa) || is_inf(bv)) begin
      r.res = {sp_, 15'h7C00}; r.flg = 4'h0; return r;
    end
    if (is_inf(cv)) begin
      r.res = {sc_, 15'h7C00}; r.flg = 4'h0; return r;
    end
    pv  = $signed({66'h0, s24(xa)} * {66'h0, s24(bv)});
    cvv = $signed({66'h0, s24(cv)} << 24);
    if (sp_) pv = -pv;
    if (sc_) cvv = -cvv;
    v = pv + cvv;
    if (v == 0) begin
      if (!ad)             r.res = {sp_, 15'h0};
      else if (sp_ == sc_) r.res = {sp_, 15'h0};
      else                 r.res = {rm == RM, 15'h0};
      r.flg = 4'h0;
      return r;
    end
    neg = v < 0;
    mag = neg ? 128'(-v) : 128'(v);
    lo = 0;
    hi = 'h7C00;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (val48(mid) <= mag) lo = mid;
      else hi = mid - 1;
    end
    if (lo == 'h7C00) begin
      code = 'h7C00;
      exact = 1'b0;
    end else begin
      lo_v = val48(lo);
      hi_v = val48(lo + 1);
      exact = (lo_v == mag);
      case (rm)
        RZ:      up = 1'b0;
        RNE:     up = ((mag << 1) > lo_v + hi_v) || (((mag << 1) == lo_v + hi_v) && lo[0]);
        RM:      up = neg && !exact;
        default: up = !neg && !exact;
      endcase
      code = lo + (up ? 1 : 0);
    end
    if (code >= 'h7C00) begin
      big = (rm == RNE) || (rm == RM && neg) || (rm == RP && !neg);
      r.res = big ? {neg, 15'h7C00} : {neg, 15'h7BFF};
      r.flg = 4'b0101;
    end else begin
      r.res = {neg, 15'(code)};
      r.flg = {2'b00, !exact && (code < 'h400), !exact};
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
`ifdef FMA16_OUTREG_EN
  always @(posedge clk or negedge reset) begin
    if (!reset) out_valid <= 1'b0;
    else        out_valid <= in_valid;
  end
`else
  always_comb out_valid = in_valid;
`endif

  always @(negedge clk) begin : monitor
    resp_t r;
    string n;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: output with no expected entry");
      end else begin
        r = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, {12'h0, result, flags}, {12'h0, r});
      end
    end
  end

  task automatic drive(input string nm, input logic [15:0] ix, input logic [15:0] iy,
                       input logic [15:0] iz, input logic im, input logic ia,
                       input logic inp, input logic inz, input logic [1:0] irm,
                       input resp_t want);
    x = ix; y = iy; z = iz;
    mul = im; add = ia; negp = inp; negz = inz; roundmode = irm;
    exp_q.push_back(want);
    name_q.push_back(nm);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand16();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return specials[$urandom_range(0, 11)];
    if (r == 1) return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 10'($urandom)};
    return 16'($urandom);
  endfunction

  initial begin
    logic [15:0] rx, ry, rz;
    logic rm_mul, rm_add, rnp, rnz;
    logic [1:0] rrm;
    resp_t p;

    reset = 1'b0;
    x = 16'h0; y = 16'h0; z = 16'h0;
    mul = 1'b0; add = 1'b0; negp = 1'b0; negz = 1'b0; roundmode = RNE;

`ifdef FMA16_OUTREG_EN
    repeat (2) @(negedge clk);
    check("reset_state", {12'h0, result, flags}, 32'h0);
    x = 16'h3C00; y = 16'h3C00; mul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", {12'h0, result, flags}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("first_capture", {12'h0, result, flags}, {12'h0, 16'h3C00, 4'h0});
`else
    x = 16'h3C00; y = 16'h3C00; mul = 1'b1;
    #1;
    check("comb_during_reset", {12'h0, result, flags}, {12'h0, 16'h3C00, 4'h0});
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
`endif

    // directed cases
    drive("mult_only",     16'h3E00, 16'h4000, 16'h0000, 1, 0, 0, 0, RNE, '{16'h4200, 4'h0});
    drive("fma_sum",       16'h3C00, 16'h3C00, 16'h3C00, 1, 1, 0, 0, RNE, '{16'h4000, 4'h0});
    drive("cancel_rne",    16'h3C00, 16'h3C00, 16'h3C00, 1, 1, 0, 1, RNE, '{16'h0000, 4'h0});
    drive("cancel_rm",     16'h3C00, 16'h3C00, 16'h3C00, 1, 1, 0, 1, RM,  '{16'h8000, 4'h0});
    drive("round_rne",     16'h3C01, 16'h3C01, 16'h0000, 1, 0, 0, 0, RNE, '{16'h3C02, 4'h1});
    drive("round_rp",      16'h3C01, 16'h3C01, 16'h0000, 1, 0, 0, 0, RP,  '{16'h3C03, 4'h1});
    drive("round_rz",      16'h3C01, 16'h3C01, 16'h0000, 1, 0, 0, 0, RZ,  '{16'h3C02, 4'h1});
    drive("ovf_rne",       16'h7BFF, 16'h4000, 16'h0000, 1, 0, 0, 0, RNE, '{16'h7C00, 4'h5});
    drive("ovf_rz",        16'h7BFF, 16'h4000, 16'h0000, 1, 0, 0, 0, RZ,  '{16'h7BFF, 4'h5});
    drive("ovf_rm_pos",    16'h7BFF, 16'h4000, 16'h0000, 1, 0, 0, 0, RM,  '{16'h7BFF, 4'h5});
    drive("ovf_rm_neg",    16'h7BFF, 16'h4000, 16'h0000, 1, 0, 1, 0, RM,  '{16'hFC00, 4'h5});
    drive("ovf_rp_neg",    16'h7BFF, 16'h4000, 16'h0000, 1, 0, 1, 0, RP,  '{16'hFBFF, 4'h5});
    drive("inv_inf_zero",  16'h7C00, 16'h0000, 16'h0000, 1, 0, 0, 0, RNE, '{16'h7E00, 4'h8});
    drive("inv_inf_inf",   16'h7C00, 16'h0000, 16'hFC00, 0, 1, 0, 0, RNE, '{16'h7E00, 4'h8});
    drive("snan_x",        16'h7D00, 16'h0000, 16'h0000, 0, 0, 0, 0, RNE, '{16'h7E00, 4'h8});
    drive("qnan_x",        16'h7E00, 16'h0000, 16'h0000, 0, 0, 0, 0, RNE, '{16'h7E00, 4'h0});
    drive("y_ignored",     16'h3C00, 16'h7D00, 16'h0000, 0, 0, 0, 0, RNE, '{16'h3C00, 4'h0});
    drive("z_ignored",     16'h3C00, 16'h0000, 16'h7D00, 0, 0, 0, 1, RNE, '{16'h3C00, 4'h0});
    drive("pos_zero_keep", 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, RM,  '{16'h0000, 4'h0});
    drive("neg_zero_keep", 16'h8000, 16'h0000, 16'h0000, 0, 0, 0, 0, RNE, '{16'h8000, 4'h0});
    drive("uflow_tie",     16'h0001, 16'h3800, 16'h0000, 1, 0, 0, 0, RNE, '{16'h0000, 4'h3});
    drive("uflow_rp",      16'h0001, 16'h3800, 16'h0000, 1, 0, 0, 0, RP,  '{16'h0001, 4'h3});
    drive("subnorm_add",   16'h0001, 16'h0000, 16'h0001, 0, 1, 0, 0, RNE, '{16'h0002, 4'h0});
    drive("min_normal",    16'h03FF, 16'h0000, 16'h0001, 0, 1, 0, 0, RNE, '{16'h0400, 4'h0});
    drive("neg_inf",       16'h7C00, 16'h0000, 16'h3C00, 0, 1, 1, 0, RNE, '{16'hFC00, 4'h0});

    // randomized cases against the reference model
    for (int i = 0; i < 3000; i++) begin
      rx = rand16(); ry = rand16(); rz = rand16();
      rm_mul = 1'($urandom_range(0, 1));
      rm_add = 1'($urandom_range(0, 1));
      rnp = 1'($urandom_range(0, 1));
      rnz = 1'($urandom_range(0, 1));
      rrm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        // addend close to minus the product: deep cancellation
        p = ref_fma(rx, ry, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, RNE);
        rz = p.res ^ 16'h8000 ^ 16'($urandom_range(0, 3));
        rm_mul = 1'b1; rm_add = 1'b1; rnp = 1'b0; rnz = 1'b0;
      end
      drive($sformatf("rand%0d", i), rx, ry, rz, rm_mul, rm_add, rnp, rnz, rrm,
            ref_fma(rx, ry, rz, rm_mul, rm_add, rnp, rnz, rrm));
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

`ifdef FMA16_OUTREG_EN
    // asynchronous reset in the middle of operation
    x = 16'h4000; y = 16'h4000; z = 16'h0000;
    mul = 1'b1; add = 1'b0; negp = 1'b0; negz = 1'b0; roundmode = RNE;
    @(posedge clk);
    #1;
    check("pre_reset_capture", {12'h0, result, flags}, {12'h0, 16'h4400, 4'h0});
    x = 16'h4200;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_clear", {12'h0, result, flags}, 32'h0);
    @(posedge clk);
    #1;
    check("reset_discard", {12'h0, result, flags}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_capture", {12'h0, result, flags}, {12'h0, 16'h4600, 4'h0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
